controller: RTL
===============

# controller

Control unit of the memory game: sequences the datapath through reset, setup, FPGA playback, user entry, check, round advance and result display. It consumes the datapath status flags (`end_fpga`, `end_user`, `end_time`, `win`, `match`) and a user "enter" button, and drives the datapath command lines (`r1`, `r2`, `e1`–`e4`, `sel`). It sits directly upstream of the datapath and shares its 50 MHz clock.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the `enter_n` synchronizer. Must be ≥ 2.
- `LOCKOUT_CYCLES`, 1_000_000: clock cycles during which further enter pulses are suppressed after one is accepted. 20 ms at 50 MHz. Must be ≥ 1.
- `clock_50` input 1: system clock, 50 MHz. This is the only clock.
- `reset` input 1: synchronous, active-high reset.
- `enter_n` input 1: raw push-button, active-low and asynchronous to the clock.
- `end_fpga` input 1: the datapath has finished showing the sequence.
- `end_user` input 1: the user has finished entering the sequence.
- `end_time` input 1: the user time counter has expired.
- `win` input 1: the round counter has reached the configured last round.
- `match` input 1: the user entry equals the FPGA sequence.
- `r1` output 1: global datapath reset (round counter, clock divider, registers).
- `r2` output 1: time counter reset.
- `e1` output 1: setup register load enable.
- `e2` output 1: time counter enable.
- `e3` output 1: FPGA sequence playback enable.
- `e4` output 1: round counter increment.
- `sel` output 1: display select.
  - 1 = game view (level / time / round).
  - 0 = result view (message / points).
- `state` output 3: current state encoding, for debug LEDs.

## Operation
- Enter path:
  - `enter_n` passes through a `SYNC_STAGES`-deep synchronizer, reset to 1.
  - A falling edge of the synchronized signal, while the lockout counter is 0, produces a one-cycle `enter_pulse`.
  - On each pulse, the lockout counter loads `LOCKOUT_CYCLES-1`. It decrements to 0 and then holds.
  - Holding the key produces exactly one pulse. Bounce inside the lockout window produces none.
- The FSM is Moore: outputs decode from the state register only. Any output not listed for a state is 0.
  - INIT (0): `r1`=1, `r2`=1, `sel`=1. Always goes to SETUP.
  - SETUP (1): `e1`=1, `sel`=1. Goes to PLAY_FPGA on `enter_pulse`.
  - PLAY_FPGA (2): `r2`=1, `e3`=1, `sel`=1. Goes to PLAY_USER when `end_fpga`=1.
  - PLAY_USER (3): `e2`=1, `sel`=1.
    - `end_time`=1 goes to RESULT.
    - Otherwise, `end_user`=1 goes to CHECK.
  - CHECK (4): `sel`=1. `match`=1 goes to NEXT_ROUND; otherwise goes to RESULT.
  - NEXT_ROUND (5): `e4`=1, `sel`=1. Always goes to EVAL.
  - EVAL (6): `sel`=1. `win`=1 goes to RESULT; otherwise goes to PLAY_FPGA. This state exists so that `win` is sampled after the round counter has updated.
  - RESULT (7): `sel`=0. Goes to INIT on `enter_pulse`.
- Boundary conditions:
  - `end_time` and `end_user` asserted together in PLAY_USER: `end_time` has priority, so the FSM goes to RESULT (loss).
  - `enter_pulse` in any state other than SETUP or RESULT is ignored and is not queued.
  - Status flags are sampled only in the states listed above. Flags asserted in any other state have no effect.
  - `reset` asserted in any state: the FSM goes to INIT and the lockout counter goes to 0 at the same edge. Synchronizer flops go to 1. No `enter_pulse` is generated in the cycle after reset releases.

## Timing
- Reset values, one edge after `reset`=1 is sampled:
  - `state`=0.
  - `r1`=1, `r2`=1, `sel`=1.
  - `e1`, `e2`, `e3`, `e4` = 0.
- Enter latency (`SYNC_STAGES`=2):
  - `enter_n`=0 is first sampled at edge N.
  - `enter_pulse` is high in the cycle after edge N+1.
  - The state changes at edge N+2.
- Each state transition takes effect at the first edge where its condition is true.
- INIT, CHECK, NEXT_ROUND and EVAL each last exactly one cycle.
- `e4` is therefore a single-cycle pulse per cleared round.
- Fixed path costs:
  - PLAY_USER → PLAY_FPGA via CHECK/NEXT_ROUND/EVAL takes 3 cycles.
  - RESULT → SETUP takes 2 cycles after `enter_pulse`.
- No combinational path from any input to any output.

## Test plan
- Reset then idle: `reset`=1 for 2 cycles. Expect `state`=0 with `r1`=`r2`=1, then `state`=1 with `e1`=1 and `sel`=1. With no key press, the FSM stays in SETUP indefinitely.
- Enter debounce (`LOCKOUT_CYCLES`=8): in SETUP, hold `enter_n`=0 for 20 cycles. Expect exactly one pulse and `state`=2 at edge N+2. Then toggle `enter_n` 3 times within 8 cycles while in RESULT. Expect no extra transition after the first.
- Winning round: in PLAY_FPGA, assert `end_fpga`; in PLAY_USER, assert `end_user` with `match`=1. Expect the sequence 3→4→5→6 with `e4` high for exactly 1 cycle. With `win`=0 at EVAL, expect `state`=2.
- Final win: same sequence but with `win`=1 at EVAL. Expect `state`=7 and `sel`=0. An enter press then gives `state` 0 followed by 1.
- Timeout priority: in PLAY_USER, assert `end_time`=1 and `end_user`=1 in the same cycle. Expect `state`=7 next edge, never 4.
- Mismatch and mid-run reset: in CHECK with `match`=0, expect `state`=7. Separately, assert `reset` while in PLAY_USER. Expect `state`=0 next edge and `e2`=0.

Source files
------------

// File: rtl/controller.sv
// Memory-game control unit: debounced enter button plus a Moore FSM that
// sequences the datapath through setup, playback, entry, check and result.
module controller #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned LOCKOUT_CYCLES = 1_000_000
) (
  input  logic       clock_50,
  input  logic       reset,
  input  logic       enter_n,
  input  logic       end_fpga,
  input  logic       end_user,
  input  logic       end_time,
  input  logic       win,
  input  logic       match,
  output logic       r1,
  output logic       r2,
  output logic       e1,
  output logic       e2,
  output logic       e3,
  output logic       e4,
  output logic       sel,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    INIT       = 3'd0,
    SETUP      = 3'd1,
    PLAY_FPGA  = 3'd2,
    PLAY_USER  = 3'd3,
    CHECK      = 3'd4,
    NEXT_ROUND = 3'd5,
    EVAL       = 3'd6,
    RESULT     = 3'd7
  } state_t;

  localparam int unsigned LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [LW-1:0]          lock_q, lock_d;
  logic                   enter_pulse;
  state_t                 state_q, state_d;

  // Output vector order: {r1, r2, e1, e2, e3, e4, sel}
  function automatic logic [6:0] decode(input state_t s);
    case (s)
      INIT:       decode = 7'b1100001;
      SETUP:      decode = 7'b0010001;
      PLAY_FPGA:  decode = 7'b0100101;
      PLAY_USER:  decode = 7'b0001001;
      CHECK:      decode = 7'b0000001;
      NEXT_ROUND: decode = 7'b0000011;
      EVAL:       decode = 7'b0000001;
      default:    decode = 7'b0000000;
    endcase
  endfunction

  assign enter_pulse = prev_q & ~sync_q[SYNC_STAGES-1] & (lock_q == '0);

  always_comb begin
    lock_d = lock_q;
    if (enter_pulse)
      lock_d = LW'(LOCKOUT_CYCLES - 1);
    else if (lock_q != '0)
      lock_d = lock_q - LW'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:       state_d = SETUP;
      SETUP:      if (enter_pulse) state_d = PLAY_FPGA;
      PLAY_FPGA:  if (end_fpga) state_d = PLAY_USER;
      PLAY_USER: begin
        if (end_time)      state_d = RESULT;
        else if (end_user) state_d = CHECK;
      end
      CHECK:      state_d = match ? NEXT_ROUND : RESULT;
      NEXT_ROUND: state_d = EVAL;
      EVAL:       state_d = win ? RESULT : PLAY_FPGA;
      RESULT:     if (enter_pulse) state_d = INIT;
      default:    state_d = INIT;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet
  // always agree with the state register.
  always_ff @(posedge clock_50) begin
    if (reset) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      lock_q  <= '0;
      state_q <= INIT;
      {r1, r2, e1, e2, e3, e4, sel} <= decode(INIT);
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], enter_n};
      prev_q  <= sync_q[SYNC_STAGES-1];
      lock_q  <= lock_d;
      state_q <= state_d;
      {r1, r2, e1, e2, e3, e4, sel} <= decode(state_d);
    end
  end

  assign state = state_q;

endmodule
